// File: rtl/pattern_scan_controller_pkg.sv
// Shared constants, FSM state encoding and small helpers for the pattern scanner.
package pattern_scan_controller_pkg;

    localparam int WIN_W   = 8;
    localparam int CNT_MAX = 255;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_e;

    // Pattern length is forced into 1..WIN_W so the compare mask is never empty.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] raw);
        if (raw == '0) begin
            return LEN_W'(1);
        end else if (raw > LEN_W'(WIN_W)) begin
            return LEN_W'(WIN_W);
        end else begin
            return raw;
        end
    endfunction

    function automatic logic [WIN_W-1:0] len_mask(input logic [LEN_W-1:0] len);
        logic [WIN_W-1:0] m;
        m = '0;
        for (int i = 0; i < WIN_W; i++) begin
            if (i < int'(len)) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/pattern_scan_controller_if.sv
// Job/stream bus of the pattern scanner. in_valid/in_ready: a word transfers on a
// rising edge where both are high; in_valid may be held, in_ready is high only in LOAD.
interface pattern_scan_controller_if;
    import pattern_scan_controller_pkg::*;

    logic                 start;
    logic [WIN_W-1:0]     pat;
    logic [LEN_W-1:0]     pat_len;
    logic                 in_valid;
    logic [WIN_W-1:0]     in_data;
    logic                 in_last;
    logic                 in_ready;
    logic                 dec;
    logic                 busy;
    logic                 done;
    logic [CNT_W-1:0]     match_cnt;
    scan_state_e          dbg_state;

    modport master (
        output start, pat, pat_len, in_valid, in_data, in_last,
        input  in_ready, dec, busy, done, match_cnt, dbg_state
    );

    modport slave (
        input  start, pat, pat_len, in_valid, in_data, in_last,
        output in_ready, dec, busy, done, match_cnt, dbg_state
    );

endinterface

// File: rtl/pattern_scan_controller_window_matcher.sv
// Sliding bit window with saturating fill count; hit reflects the window after the current shift.
module window_matcher
    import pattern_scan_controller_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             shift_en_i,
    input  logic             bit_in_i,
    input  logic             clr_i,
    input  logic [WIN_W-1:0] pat_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             hit_o
);

    logic [WIN_W-1:0] win_q, win_d;
    logic [LEN_W-1:0] seen_q, seen_d;
    logic [WIN_W-1:0] mask;

    always_comb begin
        win_d  = {win_q[WIN_W-2:0], bit_in_i};
        seen_d = (seen_q == LEN_W'(WIN_W)) ? seen_q : seen_q + LEN_W'(1);
        mask   = len_mask(len_i);
        hit_o  = shift_en_i && (seen_d >= len_i) && ((win_d & mask) == (pat_i & mask));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            win_q  <= '0;
            seen_q <= '0;
        end else if (clr_i) begin
            win_q  <= '0;
            seen_q <= '0;
        end else if (shift_en_i) begin
            win_q  <= win_d;
            seen_q <= seen_d;
        end
    end

endmodule

// File: rtl/pattern_scan_controller.sv
// Serial pattern scanner: accepts words, shifts them MSB first through a window and
// pulses dec per (possibly overlapping) match, counting matches per job.
module pattern_scan_controller
    import pattern_scan_controller_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    pattern_scan_controller_if.slave  bus
);

    scan_state_e      state_q;
    logic [WIN_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [WIN_W-1:0] data_q;
    logic             last_q;
    logic [2:0]       bit_idx_q;
    logic             dec_q;
    logic             done_q;
    logic [CNT_W-1:0] cnt_q;

    logic shift_en;
    logic clr;
    logic hit;

    assign shift_en = (state_q == ST_SHIFT);
    assign clr      = (state_q == ST_IDLE) && bus.start;

    window_matcher u_matcher (
        .clk_i      (clk),
        .rst_i      (rst),
        .shift_en_i (shift_en),
        .bit_in_i   (data_q[WIN_W-1]),
        .clr_i      (clr),
        .pat_i      (pat_q),
        .len_i      (len_q),
        .hit_o      (hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
            bit_idx_q <= '0;
            dec_q     <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            dec_q  <= hit;
            done_q <= 1'b0;
            if (hit && cnt_q != CNT_W'(CNT_MAX)) cnt_q <= cnt_q + CNT_W'(1);
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        pat_q   <= bus.pat;
                        len_q   <= clamp_len(bus.pat_len);
                        cnt_q   <= '0;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (bus.in_valid) begin
                        data_q    <= bus.in_data;
                        last_q    <= bus.in_last;
                        bit_idx_q <= '0;
                        state_q   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    data_q    <= data_q << 1;
                    bit_idx_q <= bit_idx_q + 3'd1;
                    // The final bit's hit lands in dec_q/cnt_q on the same edge that enters DONE.
                    if (bit_idx_q == 3'd7) begin
                        if (last_q) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ST_LOAD);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.dec       = dec_q;
    assign bus.done      = done_q;
    assign bus.match_cnt = cnt_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_pattern_scan_controller.sv
// Scoreboard bench for pattern_scan_controller: a bit-stream reference model feeds
// expected dec pulses and final counts; a negedge monitor compares against the DUT.
module tb_pattern_scan_controller;
    import pattern_scan_controller_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pattern_scan_controller_if bus();

    pattern_scan_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];      // expected match_cnt at each done pulse
    logic       exp_bit_q[$];  // expected dec value per shifted bit
    logic [7:0] job_words[$];
    int         age = 100;
    int         a_now;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: the job's bits form one stream; a match exists whenever the last
    // len bits of the stream (most recent = pattern bit 0) equal the pattern.
    task automatic model_job(input logic [7:0] p, input logic [3:0] raw_len, output int hits);
        int len;
        logic hist[$];
        logic m;
        logic [7:0] w;
        len  = (raw_len == 0) ? 1 : ((raw_len > 8) ? 8 : int'(raw_len));
        hits = 0;
        foreach (job_words[i]) begin
            w = job_words[i];
            for (int b = 7; b >= 0; b--) begin
                hist.push_back(w[b]);
                m = (hist.size() >= len);
                for (int k = 0; k < len; k++) begin
                    if (hist.size() > k && hist[hist.size()-1-k] != p[k]) m = 1'b0;
                end
                exp_bit_q.push_back(m);
                hits += int'(m);
            end
        end
    endtask

    // Monitor: dec may only be high 2..9 cycles after a word handshake.
    always @(negedge clk) begin
        if (rst) begin
            age = 100;
        end else begin
            a_now = age + 1;
            if (a_now >= 2 && a_now <= 9) begin
                if (exp_bit_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL dec_no_expectation: got %0d expected none at %0t", bus.dec, $time);
                end else begin
                    check("dec", 32'(bus.dec), 32'(exp_bit_q.pop_front()));
                end
            end else begin
                check("dec_quiet", 32'(bus.dec), 32'd0);
            end
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL done_unexpected: got done=1 expected done=0 at %0t", $time);
                end else begin
                    check("done_match_cnt", 32'(bus.match_cnt), 32'(exp_q.pop_front()));
                end
                check("done_busy", 32'(bus.busy), 32'd1);
            end
            age = (bus.in_valid && bus.in_ready) ? 0 : ((a_now > 1000) ? 1000 : a_now);
        end
    end

    task automatic do_start(input logic [7:0] p, input logic [3:0] l);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.pat = p; bus.pat_len = l;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input logic last);
        bit got;
        got = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = w; bus.in_last = last;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin got = 1'b1; break; end
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 50 cycles");
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.in_data = $urandom(); bus.in_last = $urandom_range(0, 1);
        if (!last) begin
            repeat ($urandom_range(0, 12)) @(posedge clk);
            #1;
        end
    endtask

    task automatic run_job(input logic [7:0] p, input logic [3:0] l, input bit poke_start);
        int hits;
        logic [7:0] expc;
        bit seen;
        model_job(p, l, hits);
        expc = (hits > CNT_MAX) ? 8'(CNT_MAX) : 8'(hits);
        exp_q.push_back(expc);
        do_start(p, l);
        if (poke_start) begin
            bus.start = 1'b1; bus.pat = ~p; bus.pat_len = 4'($urandom_range(1, 8));
            repeat (3) @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        foreach (job_words[i]) send_word(job_words[i], i == job_words.size() - 1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) begin seen = 1'b1; break; end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL done_timeout: got done=0 expected 1 within 40 cycles");
        end
        @(negedge clk);
        check("post_done_busy", 32'(bus.busy), 32'd0);
        check("post_done_cnt_held", 32'(bus.match_cnt), 32'(expc));
        check("post_done_in_ready", 32'(bus.in_ready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.pat = '0; bus.pat_len = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_dec", 32'(bus.dec), 32'd0);
        check("rst_match_cnt", 32'(bus.match_cnt), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed jobs
        job_words = '{8'hFF};             run_job(8'h07, 4'd3, 1'b0);
        job_words = '{8'h55, 8'hAA};      run_job(8'h01, 4'd2, 1'b0);
        job_words = '{8'h81};             run_job(8'h01, 4'd0, 1'b0);
        job_words.delete();
        for (int i = 0; i < 32; i++) job_words.push_back(8'hFF);
        run_job(8'h01, 4'd1, 1'b0);
        job_words = '{8'hFF, 8'h3C};      run_job(8'h07, 4'd3, 1'b1);
        job_words = '{8'hA5};             run_job(8'hA5, 4'd12, 1'b0);

        // Abort mid-SHIFT: pattern 1/len 1 over 0xFF, reset in the 4th SHIFT cycle
        do_start(8'h01, 4'd1);
        for (int i = 0; i < 8; i++) exp_bit_q.push_back(1'b1);
        bus.in_valid = 1'b1; bus.in_data = 8'hFF; bus.in_last = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_abort_cnt", 32'(bus.match_cnt), 32'd3);
        #1;
        rst = 1'b1;
        exp_bit_q.delete();
        @(negedge clk);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd0);
        check("abort_match_cnt", 32'(bus.match_cnt), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            check("abort_no_done", 32'(bus.done), 32'd0);
        end

        // Randomized jobs
        for (int j = 0; j < 10; j++) begin
            int n;
            logic [7:0] p;
            n = $urandom_range(1, 4);
            p = (j % 2 == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom());
            job_words.delete();
            for (int i = 0; i < n; i++) job_words.push_back(8'($urandom()));
            run_job(p, 4'($urandom_range(0, 15)), (j % 3 == 0));
        end

        repeat (4) @(negedge clk);
        if (exp_q.size() != 0 || exp_bit_q.size() != 0) begin
            total++; bad++;
            $display("FAIL leftover_expectations: got %0d/%0d pending expected 0/0", exp_q.size(), exp_bit_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
